// File: rtl/cmd_frame_pkg.sv
// ============================================================================
// Package   : cmd_frame_pkg
// Purpose   : Shared opcodes, request encoding, FSM states and frame-length
//             helper for the command-frame master.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmd_frame_pkg;

  // Frame opcodes, one per request type
  localparam logic [7:0] c_OPC_WR      = 8'hAA;
  localparam logic [7:0] c_OPC_RD      = 8'hBB;
  localparam logic [7:0] c_OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] c_OPC_ALU_NOP = 8'hDD;

  // Longest frame (ALU with operands) in bytes
  localparam int c_MAX_FRAME_LEN = 4;

  // Request type as presented on req_cmd
  typedef enum logic [1:0] {
    CMD_WR      = 2'd0,
    CMD_RD      = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_e;

  // Master sequencing states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_RSP = 2'd3
  } state_e;

  // Number of bytes in the frame for a given request type
  function automatic logic [2:0] frame_len(input logic [1:0] cmd);
    logic [2:0] len;
    case (cmd_e'(cmd))
      CMD_WR:      len = 3'd3;
      CMD_RD:      len = 3'd2;
      CMD_ALU_OP:  len = 3'd4;
      CMD_ALU_NOP: len = 3'd2;
      default:     len = 3'd2;
    endcase
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rsp_timer.sv
// ============================================================================
// Module    : rsp_timer
// Purpose   : 16-bit clear/enable counter that flags the last cycle of the
//             response window (count == TIMEOUT_CYCLES-1).
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module rsp_timer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam logic [15:0] c_TERM = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_count;

  // Count while enabled; clear has priority so every wait starts from zero
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= 16'd0;
    end else if (i_clr) begin
      r_count <= 16'd0;
    end else if (i_en) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_term = (r_count == c_TERM);

endmodule

`default_nettype wire

// File: rtl/cmd_frame_master.sv
// ============================================================================
// Module    : cmd_frame_master
// Purpose   : Serialises one local request into a command frame on a UART-TX
//             byte interface and returns the single response byte (or a
//             timeout indication) from the UART-RX byte interface.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_frame_master
  import cmd_frame_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_opa,
  input  logic [DATA_WIDTH-1:0] req_opb,
  input  logic [3:0]            req_fun,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_d_valid,
  input  logic                  tx_busy,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  input  logic                  rx_d_valid,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout
);

  state_e                r_state;
  logic [2:0]            r_idx;
  logic [2:0]            r_len;
  logic [DATA_WIDTH-1:0] r_frame [0:c_MAX_FRAME_LEN-1];
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_timeout;

  logic [DATA_WIDTH-1:0] w_frame [0:c_MAX_FRAME_LEN-1];
  logic [DATA_WIDTH-1:0] w_addr_ext;
  logic [DATA_WIDTH-1:0] w_fun_ext;
  logic                  w_tmr_clr;
  logic                  w_tmr_en;
  logic                  w_tmr_term;

  assign w_addr_ext = DATA_WIDTH'(req_addr);
  assign w_fun_ext  = DATA_WIDTH'(req_fun);

  // Assemble the frame image for the request currently on the req_* inputs
  always_comb begin
    w_frame[0] = DATA_WIDTH'(c_OPC_WR);
    w_frame[1] = w_addr_ext;
    w_frame[2] = req_wdata;
    w_frame[3] = '0;
    case (cmd_e'(req_cmd))
      CMD_WR: begin
        w_frame[0] = DATA_WIDTH'(c_OPC_WR);
      end
      CMD_RD: begin
        w_frame[0] = DATA_WIDTH'(c_OPC_RD);
        w_frame[2] = '0;
      end
      CMD_ALU_OP: begin
        w_frame[0] = DATA_WIDTH'(c_OPC_ALU_OP);
        w_frame[1] = req_opa;
        w_frame[2] = req_opb;
        w_frame[3] = w_fun_ext;
      end
      CMD_ALU_NOP: begin
        w_frame[0] = DATA_WIDTH'(c_OPC_ALU_NOP);
        w_frame[1] = w_fun_ext;
        w_frame[2] = '0;
      end
      default: begin
        w_frame[0] = DATA_WIDTH'(c_OPC_WR);
      end
    endcase
  end

  // Timer runs only while waiting; any other state holds it at zero
  assign w_tmr_clr = (r_state != ST_WAIT_RSP);
  assign w_tmr_en  = (r_state == ST_WAIT_RSP);

  rsp_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rsp_timer (
    .CLK    (CLK),
    .RST    (RST),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .o_term (w_tmr_term)
  );

  // Request / frame / response sequencer with registered handshake outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= ST_IDLE;
      r_idx         <= 3'd0;
      r_len         <= 3'd0;
      r_tx_data     <= '0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      for (int i = 0; i < c_MAX_FRAME_LEN; i++) begin
        r_frame[i] <= '0;
      end
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            for (int i = 0; i < c_MAX_FRAME_LEN; i++) begin
              r_frame[i] <= w_frame[i];
            end
            r_len       <= frame_len(req_cmd);
            r_idx       <= 3'd0;
            r_tx_data   <= w_frame[0];
            r_req_ready <= 1'b0;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            r_idx   <= r_idx + 3'd1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_idx < r_len) begin
            r_tx_data <= r_frame[r_idx[1:0]];
            r_state   <= ST_SEND;
          end else begin
            r_state <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          // Received data takes priority over a coincident timer expiry
          if (rx_d_valid) begin
            r_rsp_data    <= rx_p_data;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_req_ready   <= 1'b1;
            r_state       <= ST_IDLE;
          end else if (w_tmr_term) begin
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_req_ready   <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign tx_p_data   = r_tx_data;
  assign tx_d_valid  = (r_state == ST_SEND) && !tx_busy;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;

endmodule

`default_nettype wire

// File: tb/tb_cmd_frame_master.sv
// ============================================================================
// Module    : tb_cmd_frame_master
// Purpose   : Directed self-checking bench for cmd_frame_master.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_frame_master;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req_valid, req_valid_t;
  logic [1:0] req_cmd;
  logic [3:0] req_addr;
  logic [7:0] req_wdata, req_opa, req_opb;
  logic [3:0] req_fun;
  logic       tx_busy;
  logic [7:0] rx_p_data;
  logic       rx_d_valid;

  logic       req_ready_m, tx_d_valid_m, rsp_valid_m, rsp_timeout_m;
  logic [7:0] tx_p_data_m, rsp_data_m;
  logic       req_ready_t, tx_d_valid_t, rsp_valid_t, rsp_timeout_t;
  logic [7:0] tx_p_data_t, rsp_data_t;

  // Main instance uses the default timeout; the second one a short window
  cmd_frame_master dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready_m),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_opa(req_opa), .req_opb(req_opb), .req_fun(req_fun),
    .tx_p_data(tx_p_data_m), .tx_d_valid(tx_d_valid_m), .tx_busy(tx_busy),
    .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid), .rsp_valid(rsp_valid_m),
    .rsp_data(rsp_data_m), .rsp_timeout(rsp_timeout_m)
  );

  cmd_frame_master #(.TIMEOUT_CYCLES(16)) dut_to (
    .CLK(CLK), .RST(RST), .req_valid(req_valid_t), .req_ready(req_ready_t),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_opa(req_opa), .req_opb(req_opb), .req_fun(req_fun),
    .tx_p_data(tx_p_data_t), .tx_d_valid(tx_d_valid_t), .tx_busy(tx_busy),
    .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid), .rsp_valid(rsp_valid_t),
    .rsp_data(rsp_data_t), .rsp_timeout(rsp_timeout_t)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  bit sel = 1'b0;
  logic       o_ready, o_txv, o_rspv, o_rspto;
  logic [7:0] o_txd, o_rspd;
  assign o_ready = sel ? req_ready_t   : req_ready_m;
  assign o_txv   = sel ? tx_d_valid_t  : tx_d_valid_m;
  assign o_txd   = sel ? tx_p_data_t   : tx_p_data_m;
  assign o_rspv  = sel ? rsp_valid_t   : rsp_valid_m;
  assign o_rspd  = sel ? rsp_data_t    : rsp_data_m;
  assign o_rspto = sel ? rsp_timeout_t : rsp_timeout_m;

  int cmp = 0;
  int fails = 0;

  logic [7:0] sb [0:7];
  int         sc [0:7];
  int         n_strb, rsp_c, t_acc;
  bit         got_rsp, rsp_rdy, rsp_to, acc_ready, ready_early, busy_while;
  logic [7:0] rsp_d;

  // Present one request, then collect strobes and the response
  task automatic run_txn(input logic [1:0] cmd, input logic [3:0] addr,
                         input logic [7:0] wd, input logic [7:0] oa,
                         input logic [7:0] ob, input logic [3:0] fn,
                         input int exp_len, input int busy_hold,
                         input int rx_after, input logic [7:0] rx_byte,
                         input bit stray);
    int busy_cnt;
    int last_s;
    busy_cnt = 0; last_s = -1000;
    n_strb = 0; got_rsp = 0; ready_early = 0; busy_while = 0;
    rsp_c = -1; rsp_d = 8'hXX; rsp_to = 1'bx; rsp_rdy = 1'b0;
    acc_ready = o_ready;
    req_cmd = cmd; req_addr = addr; req_wdata = wd;
    req_opa = oa; req_opb = ob; req_fun = fn;
    if (sel) req_valid_t = 1'b1; else req_valid = 1'b1;
    t_acc = cyc;
    for (int k = 0; k < 400; k++) begin
      @(posedge CLK); #1;
      req_valid = 1'b0; req_valid_t = 1'b0; rx_d_valid = 1'b0;
      // scramble fields after acceptance; the DUT must hold its own copy
      req_cmd = ~cmd; req_addr = ~addr; req_wdata = ~wd;
      req_opa = ~oa; req_opb = ~ob; req_fun = ~fn;
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      if (stray && k == 0) begin
        rx_d_valid = 1'b1; rx_p_data = 8'h55;
      end
      if (rx_after > 0 && n_strb == exp_len && cyc == last_s + rx_after) begin
        rx_d_valid = 1'b1; rx_p_data = rx_byte;
      end
      #1;
      if (o_txv) begin
        if (n_strb < 8) begin
          sb[n_strb] = o_txd; sc[n_strb] = cyc - t_acc;
        end
        n_strb++;
        if (tx_busy) busy_while = 1'b1;
        busy_cnt = busy_hold;
        last_s = cyc;
      end
      if (o_rspv) begin
        got_rsp = 1'b1; rsp_d = o_rspd; rsp_to = o_rspto;
        rsp_rdy = o_ready; rsp_c = cyc - t_acc;
        break;
      end else if (o_ready) begin
        ready_early = 1'b1;
      end
    end
    rx_d_valid = 1'b0; tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    cmp++; if (req_ready_m !== 1'b1 || req_ready_t !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b/%b expected 1/1", req_ready_m, req_ready_t); end
    cmp++; if (tx_d_valid_m !== 1'b0 || tx_p_data_m !== 8'h00) begin
      fails++; $display("FAIL reset_tx: got v=%b d=%h expected v=0 d=00", tx_d_valid_m, tx_p_data_m); end
    cmp++; if (rsp_valid_m !== 1'b0 || rsp_data_m !== 8'h00 || rsp_timeout_m !== 1'b0) begin
      fails++; $display("FAIL reset_rsp: got v=%b d=%h to=%b expected 0/00/0", rsp_valid_m, rsp_data_m, rsp_timeout_m); end
    RST = 1'b1;
  endtask

  task automatic test_wr();
    logic [7:0] eb [0:2];
    int         ec [0:2];
    eb[0] = 8'hAA; eb[1] = 8'h05; eb[2] = 8'h3C;
    ec[0] = 1; ec[1] = 3; ec[2] = 5;
    sel = 1'b0;
    run_txn(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 3, 0, 3, 8'h3C, 1'b0);
    cmp++; if (n_strb !== 3) begin
      fails++; $display("FAIL wr_count: got %0d expected 3", n_strb); end
    for (int i = 0; i < 3; i++) begin
      cmp++; if (sb[i] !== eb[i] || sc[i] !== ec[i]) begin
        fails++; $display("FAIL wr_byte%0d: got %h@T+%0d expected %h@T+%0d", i, sb[i], sc[i], eb[i], ec[i]); end
    end
    cmp++; if (!got_rsp || rsp_d !== 8'h3C || rsp_to !== 1'b0 || rsp_c !== 9 || rsp_rdy !== 1'b1) begin
      fails++; $display("FAIL wr_rsp: got v=%b d=%h to=%b at T+%0d rdy=%b expected 1/3c/0 at T+9 rdy=1", got_rsp, rsp_d, rsp_to, rsp_c, rsp_rdy); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_txn(2'd0, 4'h7, 8'h81, 8'h00, 8'h00, 4'h0, 3, 0, 3, 8'h81, 1'b0);
    // next request presented in the very cycle rsp_valid is high
    run_txn(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA, 2, 0, 2, 8'h5A, 1'b0);
    cmp++; if (acc_ready !== 1'b1 || n_strb !== 2 || sc[0] !== 1) begin
      fails++; $display("FAIL b2b_accept: got rdy=%b n=%0d first@T+%0d expected 1/2/T+1", acc_ready, n_strb, sc[0]); end
    cmp++; if (sb[0] !== 8'hDD || sb[1] !== 8'h0A) begin
      fails++; $display("FAIL b2b_bytes: got %h %h expected dd 0a", sb[0], sb[1]); end
    cmp++; if (!got_rsp || rsp_d !== 8'h5A || rsp_to !== 1'b0) begin
      fails++; $display("FAIL b2b_rsp: got v=%b d=%h to=%b expected 1/5a/0", got_rsp, rsp_d, rsp_to); end
  endtask

  task automatic test_rd_delay();
    sel = 1'b0;
    run_txn(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 2, 0, 20, 8'h7E, 1'b0);
    cmp++; if (n_strb !== 2 || sb[0] !== 8'hBB || sb[1] !== 8'h09 || sc[1] !== 3) begin
      fails++; $display("FAIL rd_bytes: got n=%0d %h %h second@T+%0d expected 2 bb 09 T+3", n_strb, sb[0], sb[1], sc[1]); end
    cmp++; if (ready_early !== 1'b0 || rsp_rdy !== 1'b1) begin
      fails++; $display("FAIL rd_ready: got early=%b at_rsp=%b expected 0/1", ready_early, rsp_rdy); end
    cmp++; if (!got_rsp || rsp_d !== 8'h7E || rsp_c !== 24) begin
      fails++; $display("FAIL rd_rsp: got v=%b d=%h at T+%0d expected 1/7e at T+24", got_rsp, rsp_d, rsp_c); end
  endtask

  task automatic test_alu_busy();
    logic [7:0] eb [0:3];
    int         ec [0:3];
    eb[0] = 8'hCC; eb[1] = 8'h12; eb[2] = 8'h34; eb[3] = 8'h00;
    ec[0] = 1; ec[1] = 12; ec[2] = 23; ec[3] = 34;
    sel = 1'b0;
    run_txn(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 4, 10, 3, 8'h46, 1'b0);
    cmp++; if (n_strb !== 4 || busy_while !== 1'b0) begin
      fails++; $display("FAIL alu_strobes: got n=%0d busy_strobe=%b expected 4/0", n_strb, busy_while); end
    for (int i = 0; i < 4; i++) begin
      cmp++; if (sb[i] !== eb[i] || sc[i] !== ec[i]) begin
        fails++; $display("FAIL alu_byte%0d: got %h@T+%0d expected %h@T+%0d", i, sb[i], sc[i], eb[i], ec[i]); end
    end
    cmp++; if (!got_rsp || rsp_d !== 8'h46) begin
      fails++; $display("FAIL alu_rsp: got v=%b d=%h expected 1/46", got_rsp, rsp_d); end
  endtask

  task automatic test_stray();
    sel = 1'b0;
    run_txn(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 2, 0, 2, 8'h66, 1'b1);
    cmp++; if (n_strb !== 2 || sb[0] !== 8'hBB || sb[1] !== 8'h02) begin
      fails++; $display("FAIL stray_bytes: got n=%0d %h %h expected 2 bb 02", n_strb, sb[0], sb[1]); end
    cmp++; if (!got_rsp || rsp_d !== 8'h66 || rsp_c !== 6) begin
      fails++; $display("FAIL stray_rsp: got v=%b d=%h at T+%0d expected 1/66 at T+6", got_rsp, rsp_d, rsp_c); end
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    run_txn(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 2, 0, 0, 8'h00, 1'b0);
    cmp++; if (n_strb !== 2 || sb[0] !== 8'hDD || sb[1] !== 8'h03) begin
      fails++; $display("FAIL to_bytes: got n=%0d %h %h expected 2 dd 03", n_strb, sb[0], sb[1]); end
    cmp++; if (!got_rsp || rsp_to !== 1'b1 || rsp_d !== 8'h00 || rsp_c !== 21) begin
      fails++; $display("FAIL to_rsp: got v=%b to=%b d=%h at T+%0d expected 1/1/00 at T+21", got_rsp, rsp_to, rsp_d, rsp_c); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int  n;
    bit  bad;
    sel = 1'b0; n = 0; bad = 1'b0;
    req_cmd = 2'd0; req_addr = 4'h5; req_wdata = 8'h3C;
    req_valid = 1'b1;
    for (int k = 0; k < 20 && n < 2; k++) begin
      @(posedge CLK); #1; req_valid = 1'b0; #1;
      if (tx_d_valid_m) n++;
    end
    cmp++; if (n !== 2) begin
      fails++; $display("FAIL rstmid_setup: got %0d strobes expected 2", n); end
    @(posedge CLK); #1; RST = 1'b0; #1;
    cmp++; if (req_ready_m !== 1'b1 || tx_d_valid_m !== 1'b0 || tx_p_data_m !== 8'h00) begin
      fails++; $display("FAIL rstmid_tx: got rdy=%b v=%b d=%h expected 1/0/00", req_ready_m, tx_d_valid_m, tx_p_data_m); end
    cmp++; if (rsp_valid_m !== 1'b0 || rsp_data_m !== 8'h00 || rsp_timeout_m !== 1'b0) begin
      fails++; $display("FAIL rstmid_rsp: got v=%b d=%h to=%b expected 0/00/0", rsp_valid_m, rsp_data_m, rsp_timeout_m); end
    @(posedge CLK); #1; RST = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #2;
      if (rsp_valid_m || !req_ready_m || tx_d_valid_m) bad = 1'b1;
    end
    cmp++; if (bad !== 1'b0) begin
      fails++; $display("FAIL rstmid_quiet: got activity=%b expected 0", bad); end
    run_txn(2'd0, 4'h1, 8'h22, 8'h00, 8'h00, 4'h0, 3, 0, 3, 8'h22, 1'b0);
    cmp++; if (n_strb !== 3 || sb[0] !== 8'hAA || sb[1] !== 8'h01 || sb[2] !== 8'h22 || sc[0] !== 1) begin
      fails++; $display("FAIL rstmid_clean: got n=%0d %h %h %h first@T+%0d expected 3 aa 01 22 T+1", n_strb, sb[0], sb[1], sb[2], sc[0]); end
    cmp++; if (!got_rsp || rsp_d !== 8'h22) begin
      fails++; $display("FAIL rstmid_rsp2: got v=%b d=%h expected 1/22", got_rsp, rsp_d); end
  endtask

  initial begin
    req_valid = 1'b0; req_valid_t = 1'b0; req_cmd = 2'd0; req_addr = 4'h0;
    req_wdata = 8'h00; req_opa = 8'h00; req_opb = 8'h00; req_fun = 4'h0;
    tx_busy = 1'b0; rx_p_data = 8'h00; rx_d_valid = 1'b0;
    test_reset();
    test_wr();
    test_back_to_back();
    test_rd_delay();
    test_alu_busy();
    test_stray();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", cmp, fails);
    $finish;
  end

endmodule

`default_nettype wire
